// File: rtl/axi_ram_arbiter.sv
// axi_ram_arbiter: N-port round-robin AXI arbiter in front of one axi_ram.
// Optional AXI_RAM_ARB_PERF_EN adds per-port completed-transaction counters.
module axi_ram_arbiter #(
    parameter int N_PORTS = 4,
    parameter int ID_W    = 5,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
`ifdef AXI_RAM_ARB_PERF_EN
    output logic [N_PORTS-1:0][31:0]           perf_grants,
`endif
    input  logic [N_PORTS-1:0]                 s_awvalid,
    input  logic [N_PORTS-1:0][ID_W-1:0]       s_awid,
    input  logic [N_PORTS-1:0][ADDR_W-1:0]     s_awaddr,
    input  logic [N_PORTS-1:0][7:0]            s_awlen,
    input  logic [N_PORTS-1:0][2:0]            s_awsize,
    input  logic [N_PORTS-1:0][1:0]            s_awburst,
    output logic [N_PORTS-1:0]                 s_awready,
    input  logic [N_PORTS-1:0]                 s_wvalid,
    input  logic [N_PORTS-1:0][DATA_W-1:0]     s_wdata,
    input  logic [N_PORTS-1:0][DATA_W/8-1:0]   s_wstrb,
    input  logic [N_PORTS-1:0]                 s_wlast,
    output logic [N_PORTS-1:0]                 s_wready,
    output logic [N_PORTS-1:0]                 s_bvalid,
    output logic [N_PORTS-1:0][ID_W-1:0]       s_bid,
    input  logic [N_PORTS-1:0]                 s_bready,
    input  logic [N_PORTS-1:0]                 s_arvalid,
    input  logic [N_PORTS-1:0][ID_W-1:0]       s_arid,
    input  logic [N_PORTS-1:0][ADDR_W-1:0]     s_araddr,
    input  logic [N_PORTS-1:0][7:0]            s_arlen,
    input  logic [N_PORTS-1:0][2:0]            s_arsize,
    input  logic [N_PORTS-1:0][1:0]            s_arburst,
    output logic [N_PORTS-1:0]                 s_arready,
    output logic [N_PORTS-1:0]                 s_rvalid,
    output logic [N_PORTS-1:0][ID_W-1:0]       s_rid,
    output logic [N_PORTS-1:0][DATA_W-1:0]     s_rdata,
    output logic [N_PORTS-1:0]                 s_rlast,
    input  logic [N_PORTS-1:0]                 s_rready,
    output logic                               m_awvalid,
    output logic [ID_W-1:0]                    m_awid,
    output logic [ADDR_W-1:0]                  m_awaddr,
    output logic [7:0]                         m_awlen,
    output logic [2:0]                         m_awsize,
    output logic [1:0]                         m_awburst,
    input  logic                               m_awready,
    output logic                               m_wvalid,
    output logic [DATA_W-1:0]                  m_wdata,
    output logic [DATA_W/8-1:0]                m_wstrb,
    output logic                               m_wlast,
    input  logic                               m_wready,
    input  logic                               m_bvalid,
    input  logic [ID_W-1:0]                    m_bid,
    output logic                               m_bready,
    output logic                               m_arvalid,
    output logic [ID_W-1:0]                    m_arid,
    output logic [ADDR_W-1:0]                  m_araddr,
    output logic [7:0]                         m_arlen,
    output logic [2:0]                         m_arsize,
    output logic [1:0]                         m_arburst,
    input  logic                               m_arready,
    input  logic                               m_rvalid,
    input  logic [ID_W-1:0]                    m_rid,
    input  logic [DATA_W-1:0]                  m_rdata,
    input  logic                               m_rlast,
    output logic                               m_rready
);

    localparam int GW = $clog2(N_PORTS);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [GW-1:0]     r_grant;
    logic [GW-1:0]     r_last;
    logic [GW-1:0]     w_pick;
    logic [GW-1:0]     w_cand;
    logic [N_PORTS-1:0] w_req;
    logic              w_any;
    logic              w_pick_wr;
    logic              w_b_hs;
    logic              w_r_done;

    assign w_req    = s_awvalid | s_arvalid;
    assign w_b_hs   = (r_state == WR_RESP) && m_bvalid && s_bready[r_grant];
    assign w_r_done = (r_state == RD_DATA) && m_rvalid
                      && s_rready[r_grant] && m_rlast;

    // round-robin search starting one past the last completed port
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_last;
        w_cand = r_last;
        for (int i = 0; i < N_PORTS; i++) begin
            w_cand = GW'((int'(r_last) + 1 + i) % N_PORTS);
            if (!w_any && w_req[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
        w_pick_wr = s_awvalid[w_pick];
    end

    // state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // grant latch in IDLE; last_grant moves only on a completed transaction
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_grant <= '0;
            r_last  <= GW'(N_PORTS - 1);
        end else begin
            if (r_state == IDLE && w_any) r_grant <= w_pick;
            if (w_b_hs || w_r_done)       r_last  <= r_grant;
        end
    end

    // next-state logic; writes win over reads on the same port
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:
                if (w_any) w_next = w_pick_wr ? WR_ADDR : RD_ADDR;
            WR_ADDR:
                if (s_awvalid[r_grant] && m_awready) w_next = WR_DATA;
            WR_DATA:
                if (s_wvalid[r_grant] && m_wready && s_wlast[r_grant])
                    w_next = WR_RESP;
            WR_RESP:
                if (w_b_hs) w_next = IDLE;
            RD_ADDR:
                if (s_arvalid[r_grant] && m_arready) w_next = RD_DATA;
            RD_DATA:
                if (w_r_done) w_next = IDLE;
            default:
                w_next = IDLE;
        endcase
    end

    // channel routing: payload muxed always, handshakes only in owning state
    always_comb begin
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        s_arready = '0;
        s_rvalid  = '0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        m_awid    = s_awid[r_grant];
        m_awaddr  = s_awaddr[r_grant];
        m_awlen   = s_awlen[r_grant];
        m_awsize  = s_awsize[r_grant];
        m_awburst = s_awburst[r_grant];
        m_wdata   = s_wdata[r_grant];
        m_wstrb   = s_wstrb[r_grant];
        m_wlast   = s_wlast[r_grant];
        m_arid    = s_arid[r_grant];
        m_araddr  = s_araddr[r_grant];
        m_arlen   = s_arlen[r_grant];
        m_arsize  = s_arsize[r_grant];
        m_arburst = s_arburst[r_grant];
        for (int p = 0; p < N_PORTS; p++) begin
            s_bid[p]   = m_bid;
            s_rid[p]   = m_rid;
            s_rdata[p] = m_rdata;
            s_rlast[p] = m_rlast;
        end
        unique case (r_state)
            WR_ADDR: begin
                m_awvalid          = s_awvalid[r_grant];
                s_awready[r_grant] = m_awready;
            end
            WR_DATA: begin
                m_wvalid          = s_wvalid[r_grant];
                s_wready[r_grant] = m_wready;
            end
            WR_RESP: begin
                s_bvalid[r_grant] = m_bvalid;
                m_bready          = s_bready[r_grant];
            end
            RD_ADDR: begin
                m_arvalid          = s_arvalid[r_grant];
                s_arready[r_grant] = m_arready;
            end
            RD_DATA: begin
                s_rvalid[r_grant] = m_rvalid;
                m_rready          = s_rready[r_grant];
            end
            default: ;
        endcase
    end

`ifdef AXI_RAM_ARB_PERF_EN
    // saturating per-port completion counters
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            perf_grants <= '0;
        end else if ((w_b_hs || w_r_done) && (perf_grants[r_grant] != '1)) begin
            perf_grants[r_grant] <= perf_grants[r_grant] + 32'd1;
        end
    end
`endif

endmodule

// File: doc/axi_ram_arbiter.md
AXI_RAM_ARBITER -- requirements
Module: axi_ram_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter ID_W, default 5, AXI ID width.
REQ-003 SHALL have parameters ADDR_W, default 16, and DATA_W, default 8, for address and data width.
REQ-004 SHALL have ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have ARESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have the s_aw* bundle, per port [N_PORTS]: awvalid/awid/awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0] input; awready output.
REQ-007 SHALL have the s_w* bundle, per port: wvalid/wdata/wstrb/wlast input; wready output.
REQ-008 SHALL have the s_b* bundle, per port: bvalid/bid output; bready input.
REQ-009 SHALL have the s_ar* bundle, per port: same fields as s_aw*, input; arready output.
REQ-010 SHALL have the s_r* bundle, per port: rvalid/rid/rdata/rlast output; rready input.
REQ-011 SHALL have the m_* bundles: one identical AXI master port toward the shared axi_ram, with directions mirrored.
REQ-012 SHALL, when AXI_RAM_ARB_PERF_EN is defined, have perf_grants[N_PORTS][31:0] output: per-port completed-transaction count.

Function
REQ-013 SHALL serve one transaction at a time with FSM states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- Requests are s_awvalid or s_arvalid.
REQ-014 SHALL, in IDLE, grant round-robin starting at (last_grant+1) mod N_PORTS.
- last_grant resets to N_PORTS-1, so port 0 wins first.
REQ-015 SHALL, when the granted port asserts both awvalid and arvalid, serve the write first and let the read compete in the next arbitration.
REQ-016 SHALL register the grant decision: the IDLE->WR_ADDR/RD_ADDR transition takes 1 cycle, and no ready is asserted in IDLE.
REQ-017 SHALL, in WR_ADDR/RD_ADDR, route the granted port's address channel to m_*.
- m_awvalid = s_awvalid[g]; s_awready[g] = m_awready, combinational.
- Advance on the m-side handshake.
REQ-018 SHALL, in WR_DATA, route s_w*[g] to m_w*; leave on the handshake with wlast=1 and enter WR_RESP.
REQ-019 SHALL, in WR_RESP, route m_b* to s_b*[g]; on the B handshake, update last_grant=g and return to IDLE.
REQ-020 SHALL, in RD_DATA, route m_r* to s_r*[g]; on the R handshake with rlast=1, update last_grant and return to IDLE.
REQ-021 SHALL pass IDs unmodified and drive all non-granted ports' ready/valid outputs to 0.
REQ-022 SHALL drive every m_*valid and m_*ready to 0 outside its owning state.
REQ-023 SHALL NOT drop a request: a port whose valid is held is granted within N_PORTS transactions.
REQ-024 SHALL keep the grant while valid is low mid-burst (no timeout; a stalled requester stalls the RAM).

Reset
REQ-025 SHALL, while ARESET=1, force state IDLE, last_grant=N_PORTS-1, every output valid/ready=0, and perf counters=0.
REQ-026 SHALL treat ARESET asserted mid-burst as an abort: outputs drop within the same cycle, asynchronously, and no B/R is completed afterward.

Configuration
REQ-027 SHALL, with AXI_RAM_ARB_PERF_EN defined, increment perf_grants[g] by 1 at each B or final-R handshake, saturating at 2^32-1.
REQ-028 SHALL, without AXI_RAM_ARB_PERF_EN, omit the perf_grants port and its counters entirely; arbitration is unchanged.

Verification
REQ-029 SHALL cover, after reset release, all 4 ports asserting arvalid with arlen=0 held:
- Required grant order 0,1,2,3,0.
- Each R beat returns the matching ARID.
REQ-030 SHALL cover port 2 issuing a write (awid=5, awaddr=0x0010, awlen=3, 4 W beats) and then reading the same address:
- B on port 2 with bid=5.
- Read returns the 4 written bytes in order.
REQ-031 SHALL cover port 1 asserting awvalid and arvalid simultaneously with other ports idle:
- Write completes (B handshake) before m_arvalid rises.
REQ-032 SHALL cover ARESET pulsed during the 3rd beat of an 8-beat read:
- All s_rvalid and m_rready are 0 that cycle.
- The next grant after release goes to port 0.
REQ-033 SHALL cover, with AXI_RAM_ARB_PERF_EN, 3 reads by port 3 and 1 write by port 0:
- perf_grants[3]=3, perf_grants[0]=1, others 0.
